// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if
//   Request/response bundle for the bit-serial ALU sequencer.
//
//   Handshake: the master raises start with dataA/dataB/Signal valid. The
//   request is taken on a rising clk edge only while busy is low. After that
//   edge busy stays high until the operation retires. done pulses high for
//   exactly one cycle, on the same edge that dataOut changes. A start seen
//   while busy is high is dropped and is not queued.
//
//   Signals
//     start     master -> slave  request (level, sampled while idle)
//     dataA     master -> slave  operand A
//     dataB     master -> slave  operand B
//     Signal    master -> slave  6-bit function code
//     busy      slave -> master  operation in flight
//     done      slave -> master  one-cycle completion pulse
//     dataOut   slave -> master  registered result
//     dbg_state slave -> master  FSM state, for observation only
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;
    logic [1:0]       dbg_state;

    modport master (
        output start, dataA, dataB, Signal,
        input  busy, done, dataOut, dbg_state
    );

    modport slave (
        input  start, dataA, dataB, Signal,
        output busy, done, dataOut, dbg_state
    );
endinterface

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl
//   Sequencer plus 1-bit ALU slice. The block processes the operands one bit
//   per cycle, LSB first. The slice provides AND, OR and a full adder with
//   B-invert, and a carry flop links successive bits. A request takes WIDTH
//   RUN cycles and then one DONE cycle.
//
//   Ports
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset
//     bus   serial_alu_ctrl_if.slave (start/operands in; busy/done/dataOut out)
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_alu_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_SLT = 6'b101010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             binv_q, binv_d;
    logic [5:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // 1-bit slice signals
    logic             a_bit, b_bit, sum_bit, cout_bit, slice_bit, less;
    logic [WIDTH-1:0] shift_next;
    logic             sub_like;

    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q] ^ binv_q;
        sum_bit  = a_bit ^ b_bit ^ carry_q;
        cout_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

        case (op_q)
            OP_AND:                 slice_bit = a_bit & b_bit;
            OP_OR:                  slice_bit = a_bit | b_bit;
            OP_ADD, OP_SUB, OP_SLT: slice_bit = sum_bit;
            default:                slice_bit = 1'b0;
        endcase

        // Results enter at the MSB end. After WIDTH shifts, bit 0 has
        // reached position 0.
        shift_next = {slice_bit, shift_q[WIDTH-1:1]};

        // On the MSB cycle, carry_q is the carry into the MSB. XOR with the
        // carry-out gives signed overflow, which corrects the sign of A-B.
        less = sum_bit ^ (carry_q ^ cout_bit);

        sub_like = (bus.Signal == OP_SUB) || (bus.Signal == OP_SLT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        binv_d  = binv_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.dataA;
                    b_d     = bus.dataB;
                    op_d    = bus.Signal;
                    cnt_d   = '0;
                    binv_d  = sub_like;
                    carry_d = sub_like;   // +1 completes the two's complement of B
                end
            end
            RUN: begin
                shift_d = shift_next;
                carry_d = cout_bit;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dout_d  = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, less}
                                               : shift_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            binv_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            binv_q  <= binv_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dataOut   = dout_q;
    assign bus.dbg_state = state_q;
endmodule
